exec_ctrl_unit: RTL and testbench
=================================

// Module: exec_ctrl_unit
// PURPOSE
//   RV32I control decoder, D->E pipeline register, and execute datapath (ALU + branch comparator) in one block.
//   Sits between the instruction decoder/register file and the memory stage of the 5-stage pipeline.
//   Decodes the D-stage instruction fields into control signals and registers them, inserting a bubble on stall/flush.
//   In E it computes the ALU result and the PC-redirect flag from the bypassed operands.
// PARAMETERS
//   XLEN  32  datapath width; only 32 is supported.
// PORTS
//   clock         in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high; clears the E register
//   opcode_d      in   7   D-stage opcode
//   funct3_d      in   3   D-stage funct3
//   funct7_d      in   7   D-stage funct7 (inst[31:25])
//   imm_d         in   32  D-stage sign-extended immediate
//   pc_d          in   32  D-stage PC
//   bubble_d      in   1   stall or flush: load a NOP into the E register
//   data_rs1_e    in   32  E-stage rs1 value, already bypassed
//   data_rs2_e    in   32  E-stage rs2 value, already bypassed
//   regwen_e      out  1   register write enable
//   memrw_e       out  1   1 = data-memory write (stores)
//   wbsel_e       out  2   00 = ALU, 01 = PC+4 (JAL/JALR), 10 = data memory (loads)
//   access_size_e out  2   funct3[1:0]: 0 = byte, 1 = half, 2 = word
//   alu_out_e     out  32  ALU result / branch or jump target / effective address
//   pcsel_e       out  1   1 = redirect fetch to alu_out_e
//   illegal_e     out  1   unknown non-zero opcode in E (see CONFIGURATION)
// BEHAVIOUR
//   Control (combinational from D fields), by opcode:
//     LUI/AUIPC/OP-IMM/OP: regwen = 1.
//     LOAD: regwen = 1, wbsel = 10.
//     STORE: memrw = 1.
//     JAL/JALR: regwen = 1, wbsel = 01.
//   asel (0 = rs1, 1 = PC): 1 for AUIPC, JAL, BRANCH.
//   bsel (0 = rs2, 1 = imm): 1 for every opcode except OP.
//   brun = 1 when funct3 is 110 or 111.
//   Opcode 0000000 or any unknown opcode: all controls 0.
//   E register: loads on posedge; bubble_d=1 loads all-zero (opcode = 0). Async reset also forces all zero.
//   Outputs are valid the cycle after the D inputs are presented.
//   ALU (combinational from E register + operands):
//     a = asel ? pc_e : rs1; b = bsel ? imm_e : rs2.
//     OP/OP-IMM: ADD/SUB (SUB only for OP with funct7[5] = 1), SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND.
//     Shift amount = b[4:0]; SRA/SRAI selected by funct7[5]; ADDI ignores funct7.
//     LUI: out = b. AUIPC/JAL/BRANCH/LOAD/STORE: out = a + b. JALR: out = (a + b) & ~1.
//     All arithmetic is mod 2^32. Unknown or zero opcode: out = 0.
//   Branch comparator: compares rs1 vs rs2, signed unless brun.
//     BEQ, BNE, BLT, BGE, BLTU, BGEU per funct3; funct3 010 or 011 never taken.
//     pcsel = taken branch | JAL | JALR; 0 otherwise, including in a bubble.
//   bubble_d together with a valid instruction: the bubble wins.
//   Reset mid-operation: outputs drop to NOP values immediately, without waiting for a clock edge.
// CONFIGURATION
//   EXEC_ILLEGAL_OP_EN defined:
//     illegal_e = 1 while opcode_e is non-zero and not one of the 9 RV32I opcodes above.
//     While illegal_e = 1, regwen_e and memrw_e are additionally forced to 0.
//   EXEC_ILLEGAL_OP_EN undefined: illegal_e is tied to 0.
// STRUCTURE
//   Shared package exec_pkg holds:
//     opcode localparams (OPC_LUI ... OPC_OP);
//     funct3 codes;
//     wbsel encodings (WB_ALU, WB_PC4, WB_MEM);
//     access-size codes.
//   One sub-module: exec_alu (pure combinational ALU + branch comparator).
//   Control decode and the E register stay in the top.
// TESTING
//   Reset: assert reset mid-cycle.
//     -> regwen_e = memrw_e = 0, wbsel_e = 00, alu_out_e = 0, pcsel_e = 0, with no clock edge needed.
//   ADD then SUB (opcode 0110011), rs1 = 5, rs2 = 7:
//     ADD -> alu_out_e = 12, regwen_e = 1, wbsel_e = 00.
//     SUB (funct7 = 0100000) -> alu_out_e = 0xFFFFFFFE.
//   SRAI (0010011, funct3 101, funct7 0100000), rs1 = 0x80000000, imm = 4:
//     -> alu_out_e = 0xF8000000.
//     Same with funct7 = 0 (SRLI) -> 0x08000000.
//   Branches, pc_d = 0x01000010, imm = -8, rs1 = 1, rs2 = 0xFFFFFFFF:
//     BLTU -> pcsel_e = 1, alu_out_e = 0x01000008.
//     BLT -> pcsel_e = 0.
//   JALR, rs1 = 0x01000003, imm = 4:
//     -> alu_out_e = 0x01000006, pcsel_e = 1, wbsel_e = 01, regwen_e = 1.
//   Bubble: LW with bubble_d = 1 -> next cycle all outputs zero.
//     Drop bubble_d -> wbsel_e = 10, access_size_e = 2.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the execute-stage control unit.
//   - RV32I opcode codes (OPC_*)
//   - ALU and branch funct3 codes (F3_*)
//   - write-back select encodings (WB_*)
//   - memory access-size codes (SIZE_*)
//   - is_rv32i_opcode(): 1 for any of the nine supported opcodes
package exec_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_PC4 = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic logic is_rv32i_opcode(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: purely combinational RV32I ALU and branch comparator.
// Ports:
//   opcode, funct3, funct7_5 : instruction fields held in the E register
//   asel, bsel, brun         : operand / comparison selects
//   pc, imm, rs1, rs2        : operand sources
//   alu_out                  : ALU result, target address or effective address
//   pcsel                    : 1 = redirect fetch (taken branch, JAL, JALR)
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              asel,
  input  logic              bsel,
  input  logic              brun,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic [DATA_W-1:0] alu_out,
  output logic              pcsel
);

  logic signed [DATA_W-1:0] a;
  logic signed [DATA_W-1:0] b;
  logic        [DATA_W-1:0] sum;
  logic signed [DATA_W-1:0] sra_res;
  logic        [DATA_W-1:0] srl_res;
  logic        [4:0]        shamt;
  logic                     sub_en;
  logic                     br_eq;
  logic                     br_lt;

  assign a       = asel ? pc : rs1;
  assign b       = bsel ? imm : rs2;
  assign sum     = a + b;
  assign shamt   = b[4:0];
  // Kept as separate signals so the arithmetic shift is never evaluated
  // in an unsigned context.
  assign sra_res = a >>> shamt;
  assign srl_res = $unsigned(a) >> shamt;
  // OP-IMM has no SUBI: funct7 there is part of the immediate.
  assign sub_en  = (opcode == OPC_OP) && funct7_5;

  assign br_eq = (rs1 == rs2);
  assign br_lt = brun ? ($unsigned(rs1) < $unsigned(rs2))
                      : ($signed(rs1) < $signed(rs2));

  always_comb begin
    alu_out = '0;
    pcsel   = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (funct3)
          F3_ADD:  alu_out = sub_en ? (a - b) : sum;
          F3_SLL:  alu_out = a << shamt;
          F3_SLT:  alu_out = {{(DATA_W-1){1'b0}}, (a < b)};
          F3_SLTU: alu_out = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
          F3_XOR:  alu_out = a ^ b;
          F3_SR:   alu_out = funct7_5 ? sra_res : srl_res;
          F3_OR:   alu_out = a | b;
          default: alu_out = a & b;
        endcase
      end
      OPC_LUI:  alu_out = b;
      OPC_AUIPC, OPC_JAL, OPC_LOAD, OPC_STORE: alu_out = sum;
      OPC_JALR: begin
        alu_out = {sum[DATA_W-1:1], 1'b0};
        pcsel   = 1'b1;
      end
      OPC_BRANCH: begin
        alu_out = sum;
        case (funct3)
          F3_BEQ:           pcsel = br_eq;
          F3_BNE:           pcsel = ~br_eq;
          F3_BLT, F3_BLTU:  pcsel = br_lt;
          F3_BGE, F3_BGEU:  pcsel = ~br_lt;
          default:          pcsel = 1'b0;
        endcase
      end
      default: alu_out = '0;
    endcase
    if (opcode == OPC_JAL) pcsel = 1'b1;
  end

endmodule

// File: rtl/exec_ctrl_unit.sv
// exec_ctrl_unit: RV32I control decode, D->E pipeline register and execute
// datapath (ALU + branch comparator).
// Optional feature macro: EXEC_ILLEGAL_OP_EN (flags unknown non-zero opcodes
// in E and suppresses their register/memory writes).
// Ports:
//   clock, reset            : clock; async active-high reset of the E register
//   opcode_d .. pc_d        : D-stage instruction fields, immediate and PC
//   bubble_d                : stall/flush, loads a NOP into E
//   data_rs1_e, data_rs2_e  : bypassed E-stage register operands
//   regwen_e, memrw_e       : register write / data-memory write enables
//   wbsel_e, access_size_e  : write-back select and memory access size
//   alu_out_e, pcsel_e      : ALU result and fetch-redirect flag
//   illegal_e               : unknown opcode in E (0 unless macro defined)
module exec_ctrl_unit
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [6:0]        opcode_d,
  input  logic [2:0]        funct3_d,
  input  logic [6:0]        funct7_d,
  input  logic [DATA_W-1:0] imm_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic              bubble_d,
  input  logic [DATA_W-1:0] data_rs1_e,
  input  logic [DATA_W-1:0] data_rs2_e,
  output logic              regwen_e,
  output logic              memrw_e,
  output logic [1:0]        wbsel_e,
  output logic [1:0]        access_size_e,
  output logic [DATA_W-1:0] alu_out_e,
  output logic              pcsel_e,
  output logic              illegal_e
);

  logic       vld_p0, regwen_p0, memrw_p0, asel_p0, bsel_p0, brun_p0, known_p0;
  logic [1:0] wbsel_p0;

  logic              vld_p1, regwen_p1, memrw_p1, asel_p1, bsel_p1, brun_p1, funct7_5_p1;
  logic [1:0]        wbsel_p1;
  logic [6:0]        opcode_p1;
  logic [2:0]        funct3_p1;
  logic [DATA_W-1:0] imm_p1, pc_p1;
  logic              pcsel_p1;

  logic unused_funct7;
  assign unused_funct7 = ^{funct7_d[6], funct7_d[4:0]};

  // ---- stage p0: decode D-stage fields ----
  assign vld_p0 = ~bubble_d;

  always_comb begin
    regwen_p0 = 1'b0;
    memrw_p0  = 1'b0;
    wbsel_p0  = WB_ALU;
    asel_p0   = 1'b0;
    bsel_p0   = 1'b0;
    known_p0  = 1'b1;
    case (opcode_d)
      OPC_LUI:    begin regwen_p0 = 1'b1; bsel_p0 = 1'b1; end
      OPC_AUIPC:  begin regwen_p0 = 1'b1; asel_p0 = 1'b1; bsel_p0 = 1'b1; end
      OPC_OP_IMM: begin regwen_p0 = 1'b1; bsel_p0 = 1'b1; end
      OPC_OP:     regwen_p0 = 1'b1;
      OPC_LOAD:   begin regwen_p0 = 1'b1; wbsel_p0 = WB_MEM; bsel_p0 = 1'b1; end
      OPC_STORE:  begin memrw_p0 = 1'b1; bsel_p0 = 1'b1; end
      OPC_JAL:    begin regwen_p0 = 1'b1; wbsel_p0 = WB_PC4; asel_p0 = 1'b1; bsel_p0 = 1'b1; end
      OPC_JALR:   begin regwen_p0 = 1'b1; wbsel_p0 = WB_PC4; bsel_p0 = 1'b1; end
      OPC_BRANCH: begin asel_p0 = 1'b1; bsel_p0 = 1'b1; end
      default:    known_p0 = 1'b0;
    endcase
    brun_p0 = known_p0 && (funct3_d[2:1] == 2'b11);
  end

  // ---- stage p1: E register (bubble loads an all-zero NOP) ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      opcode_p1   <= '0;
      funct3_p1   <= '0;
      funct7_5_p1 <= 1'b0;
      regwen_p1   <= 1'b0;
      memrw_p1    <= 1'b0;
      wbsel_p1    <= WB_ALU;
      asel_p1     <= 1'b0;
      bsel_p1     <= 1'b0;
      brun_p1     <= 1'b0;
    end else if (!vld_p0) begin
      vld_p1      <= 1'b0;
      opcode_p1   <= '0;
      funct3_p1   <= '0;
      funct7_5_p1 <= 1'b0;
      regwen_p1   <= 1'b0;
      memrw_p1    <= 1'b0;
      wbsel_p1    <= WB_ALU;
      asel_p1     <= 1'b0;
      bsel_p1     <= 1'b0;
      brun_p1     <= 1'b0;
    end else begin
      vld_p1      <= 1'b1;
      opcode_p1   <= opcode_d;
      funct3_p1   <= funct3_d;
      funct7_5_p1 <= funct7_d[5];
      regwen_p1   <= regwen_p0;
      memrw_p1    <= memrw_p0;
      wbsel_p1    <= wbsel_p0;
      asel_p1     <= asel_p0;
      bsel_p1     <= bsel_p0;
      brun_p1     <= brun_p0;
    end
  end

  // Operand data is not reset: a zero opcode already forces every output
  // to its NOP value regardless of what these hold.
  always_ff @(posedge clock) begin
    imm_p1 <= vld_p0 ? imm_d : '0;
    pc_p1  <= vld_p0 ? pc_d  : '0;
  end

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode   (opcode_p1),
    .funct3   (funct3_p1),
    .funct7_5 (funct7_5_p1),
    .asel     (asel_p1),
    .bsel     (bsel_p1),
    .brun     (brun_p1),
    .pc       (pc_p1),
    .imm      (imm_p1),
    .rs1      (data_rs1_e),
    .rs2      (data_rs2_e),
    .alu_out  (alu_out_e),
    .pcsel    (pcsel_p1)
  );

`ifdef EXEC_ILLEGAL_OP_EN
  assign illegal_e = vld_p1 && (opcode_p1 != '0) && !is_rv32i_opcode(opcode_p1);
`else
  assign illegal_e = 1'b0;
`endif

  assign regwen_e      = regwen_p1 & ~illegal_e;
  assign memrw_e       = memrw_p1 & ~illegal_e;
  assign wbsel_e       = wbsel_p1;
  assign access_size_e = funct3_p1[1:0];
  assign pcsel_e       = vld_p1 & pcsel_p1;

endmodule

// File: tb/tb_exec_ctrl_unit.sv
module tb_exec_ctrl_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode_d;
  logic [2:0]  funct3_d;
  logic [6:0]  funct7_d;
  logic [31:0] imm_d, pc_d;
  logic        bubble_d;
  logic [31:0] data_rs1_e, data_rs2_e;
  logic        regwen_e, memrw_e, pcsel_e, illegal_e;
  logic [1:0]  wbsel_e, access_size_e;
  logic [31:0] alu_out_e;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        regwen;
    logic        memrw;
    logic [1:0]  wbsel;
    logic [1:0]  size;
    logic [31:0] alu;
    logic        pcsel;
    logic        illegal;
  } exp_t;

  exec_ctrl_unit dut (
    .clock         (clock),
    .reset         (reset),
    .opcode_d      (opcode_d),
    .funct3_d      (funct3_d),
    .funct7_d      (funct7_d),
    .imm_d         (imm_d),
    .pc_d          (pc_d),
    .bubble_d      (bubble_d),
    .data_rs1_e    (data_rs1_e),
    .data_rs2_e    (data_rs2_e),
    .regwen_e      (regwen_e),
    .memrw_e       (memrw_e),
    .wbsel_e       (wbsel_e),
    .access_size_e (access_size_e),
    .alu_out_e     (alu_out_e),
    .pcsel_e       (pcsel_e),
    .illegal_e     (illegal_e)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Register/immediate arithmetic as the ISA defines it.
  function automatic logic [31:0] arith(input logic [2:0] f3, input logic [31:0] x,
                                        input logic [31:0] y, input bit sub, input bit sra);
    int unsigned sh;
    sh = y[4:0];
    case (f3)
      3'd0: if (sub) return x - y; else return x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: if (sra) return $signed(x) >>> sh; else return x >> sh;
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic [31:0] pc, input bit bub,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    e = '0;
    if (bub) return e;
    e.size = f3[1:0];
    case (op)
      7'b0110111: begin e.regwen = 1; e.alu = imm; end
      7'b0010111: begin e.regwen = 1; e.alu = pc + imm; end
      7'b1101111: begin e.regwen = 1; e.wbsel = 2'b01; e.alu = pc + imm; e.pcsel = 1; end
      7'b1100111: begin e.regwen = 1; e.wbsel = 2'b01; e.alu = (r1 + imm) & ~32'd1; e.pcsel = 1; end
      7'b1100011: begin e.alu = pc + imm; e.pcsel = branch_taken(f3, r1, r2); end
      7'b0000011: begin e.regwen = 1; e.wbsel = 2'b10; e.alu = r1 + imm; end
      7'b0100011: begin e.memrw = 1; e.alu = r1 + imm; end
      7'b0010011: begin e.regwen = 1; e.alu = arith(f3, r1, imm, 1'b0, f7[5]); end
      7'b0110011: begin e.regwen = 1; e.alu = arith(f3, r1, r2, f7[5], f7[5]); end
      default: begin
`ifdef EXEC_ILLEGAL_OP_EN
        e.illegal = (op != 7'd0);
`endif
      end
    endcase
    return e;
  endfunction

  task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] imm, input logic [31:0] pc, input bit bub,
                     input logic [31:0] r1, input logic [31:0] r2);
    @(negedge clock);
    opcode_d = op; funct3_d = f3; funct7_d = f7; imm_d = imm; pc_d = pc; bubble_d = bub;
    @(posedge clock);
    #1;
    data_rs1_e = r1; data_rs2_e = r2;
    #1;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".regwen"},  32'(regwen_e),      32'(e.regwen));
    check({tag, ".memrw"},   32'(memrw_e),       32'(e.memrw));
    check({tag, ".wbsel"},   32'(wbsel_e),       32'(e.wbsel));
    check({tag, ".size"},    32'(access_size_e), 32'(e.size));
    check({tag, ".alu"},     alu_out_e,          e.alu);
    check({tag, ".pcsel"},   32'(pcsel_e),       32'(e.pcsel));
    check({tag, ".illegal"}, 32'(illegal_e),     32'(e.illegal));
  endtask

  function automatic logic [6:0] pick_op(input int i);
    case (i)
      0: return 7'b0110111;
      1: return 7'b0010111;
      2: return 7'b1101111;
      3: return 7'b1100111;
      4: return 7'b1100011;
      5: return 7'b0000011;
      6: return 7'b0100011;
      7: return 7'b0010011;
      8: return 7'b0110011;
      9: return 7'b0000000;
      default: return 7'b1111111;
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] imm, pc, r1, r2;
    bit bub;
    int sel;

    reset = 1'b1;
    opcode_d = '0; funct3_d = '0; funct7_d = '0; imm_d = '0; pc_d = '0; bubble_d = 1'b0;
    data_rs1_e = '0; data_rs2_e = '0;
    #3;
    check("rst0.regwen", 32'(regwen_e), 32'd0);
    check("rst0.memrw",  32'(memrw_e),  32'd0);
    check("rst0.wbsel",  32'(wbsel_e),  32'd0);
    check("rst0.alu",    alu_out_e,     32'd0);
    check("rst0.pcsel",  32'(pcsel_e),  32'd0);
    #4 reset = 1'b0;

    run(7'b0110011, 3'b000, 7'b0000000, 32'd0, 32'd0, 0, 32'd5, 32'd7);
    check("add.alu",    alu_out_e,     32'd12);
    check("add.regwen", 32'(regwen_e), 32'd1);
    check("add.wbsel",  32'(wbsel_e),  32'd0);
    run(7'b0110011, 3'b000, 7'b0100000, 32'd0, 32'd0, 0, 32'd5, 32'd7);
    check("sub.alu", alu_out_e, 32'hFFFF_FFFE);

    run(7'b0010011, 3'b101, 7'b0100000, 32'd4, 32'd0, 0, 32'h8000_0000, 32'd0);
    check("srai.alu", alu_out_e, 32'hF800_0000);
    run(7'b0010011, 3'b101, 7'b0000000, 32'd4, 32'd0, 0, 32'h8000_0000, 32'd0);
    check("srli.alu", alu_out_e, 32'h0800_0000);

    run(7'b1100011, 3'b110, 7'd0, 32'hFFFF_FFF8, 32'h0100_0010, 0, 32'd1, 32'hFFFF_FFFF);
    check("bltu.pcsel", 32'(pcsel_e), 32'd1);
    check("bltu.alu",   alu_out_e,    32'h0100_0008);
    run(7'b1100011, 3'b100, 7'd0, 32'hFFFF_FFF8, 32'h0100_0010, 0, 32'd1, 32'hFFFF_FFFF);
    check("blt.pcsel", 32'(pcsel_e), 32'd0);

    run(7'b1100111, 3'b000, 7'd0, 32'd4, 32'h0000_0200, 0, 32'h0100_0003, 32'd0);
    check("jalr.alu",    alu_out_e,     32'h0100_0006);
    check("jalr.pcsel",  32'(pcsel_e),  32'd1);
    check("jalr.wbsel",  32'(wbsel_e),  32'd1);
    check("jalr.regwen", 32'(regwen_e), 32'd1);

    run(7'b0000011, 3'b010, 7'd0, 32'd4, 32'h40, 1, 32'h100, 32'd0);
    check_all("bubble", '0);
    run(7'b0000011, 3'b010, 7'd0, 32'd4, 32'h40, 0, 32'h100, 32'd0);
    check("lw.wbsel", 32'(wbsel_e),       32'd2);
    check("lw.size",  32'(access_size_e), 32'd2);
    check("lw.alu",   alu_out_e,          32'h104);

    // Mid-cycle reset while a JAL sits in E.
    run(7'b1101111, 3'b000, 7'd0, 32'h10, 32'h100, 0, 32'd0, 32'd0);
    check("jal.pcsel", 32'(pcsel_e), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst1.regwen", 32'(regwen_e), 32'd0);
    check("rst1.memrw",  32'(memrw_e),  32'd0);
    check("rst1.wbsel",  32'(wbsel_e),  32'd0);
    check("rst1.alu",    alu_out_e,     32'd0);
    check("rst1.pcsel",  32'(pcsel_e),  32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 10);
      op  = pick_op(sel);
      f3  = (sel >= 9) ? 3'd0 : 3'($urandom_range(0, 7));
      f7  = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom);
      imm = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom))) : $urandom;
      pc  = {$urandom, 2'b00} >> 2;
      r1  = $urandom;
      r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      bub = ($urandom_range(0, 7) == 0);
      run(op, f3, f7, imm, pc, bub, r1, r2);
      e = model(op, f3, f7, imm, pc, bub, r1, r2);
      check_all($sformatf("rnd%0d_op%02h", n, op), e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
